mem_arbiter: RTL

- Shares a single wishbone slave port (the L2/physical memory) between two pipeline masters: instruction fetch (I) and the MEM-stage data port (D).
- Grants the slave to one master per transaction using round-robin fairness.
- Forwards the granted master's request to the slave and routes ACK/RTY back to that master only.
- Includes a watchdog that aborts transactions the slave never completes.

---
 rtl/lc3b_types.sv | 19 +
 rtl/arb_watchdog.sv | 33 +++
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// lc3b_types : shared LC-3b types (memory line, address, selects, arbiter FSM)
// Revision   : 1.0
// ============================================================================
package lc3b_types;

  typedef logic [127:0] lc3b_mem_line;
  typedef logic [11:0]  lc3b_line_addr;
  typedef logic [15:0]  lc3b_mem_sel;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } lc3b_arb_state;

endpackage
`default_nettype wire

// File: rtl/arb_watchdog.sv
`default_nettype none
// ============================================================================
// arb_watchdog : clearable wait counter flagging a stalled slave transaction
// Revision     : 1.0
// ============================================================================
module arb_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  localparam logic [CNT_W-1:0] c_limit   = CNT_W'(TIMEOUT);
  localparam logic             c_enabled = (TIMEOUT != 0);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && c_enabled) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_timeout = c_enabled && (r_cnt == c_limit);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : round-robin wishbone arbiter (I fetch vs D mem) with watchdog
// Revision    : 1.0
// ============================================================================
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cyc,
  input  logic          i_stb,
  input  logic          i_we,
  input  lc3b_line_addr i_adr,
  input  lc3b_mem_sel   i_sel,
  input  lc3b_mem_line  i_dat_m,
  output logic          i_ack,
  output logic          i_rty,
  input  logic          d_cyc,
  input  logic          d_stb,
  input  logic          d_we,
  input  lc3b_line_addr d_adr,
  input  lc3b_mem_sel   d_sel,
  input  lc3b_mem_line  d_dat_m,
  output logic          d_ack,
  output logic          d_rty,
  output lc3b_mem_line  dat_s,
  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output lc3b_line_addr s_adr,
  output lc3b_mem_sel   s_sel,
  output lc3b_mem_line  s_dat_m,
  input  logic          s_ack,
  input  logic          s_rty,
  input  lc3b_mem_line  s_dat_s,
  output logic [1:0]    gnt
);

  lc3b_arb_state r_state;
  lc3b_arb_state w_next;
  logic          r_last;
  logic          w_last_nxt;
  logic          w_wd_clr;
  logic          w_wd_en;
  logic          w_timeout;
  logic          w_i_req;
  logic          w_d_req;
  logic          w_resp;

  assign w_i_req = i_cyc & i_stb;
  assign w_d_req = d_cyc & d_stb;
  assign w_resp  = s_ack | s_rty;
  assign dat_s   = s_dat_s;

  arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wd (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_wd_clr),
    .i_en      (w_wd_en),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_last_nxt = r_last;
    w_wd_clr   = 1'b0;
    w_wd_en    = 1'b0;
    gnt        = 2'b00;
    s_cyc      = 1'b0;
    s_stb      = 1'b0;
    s_we       = d_we;
    s_adr      = d_adr;
    s_sel      = d_sel;
    s_dat_m    = d_dat_m;
    i_ack      = 1'b0;
    i_rty      = 1'b0;
    d_ack      = 1'b0;
    d_rty      = 1'b0;

    case (r_state)
      ARB_IDLE: begin
        w_wd_clr = 1'b1;
        if (w_i_req && w_d_req) begin
          w_next = r_last ? ARB_GNT_I : ARB_GNT_D;
        end else if (w_i_req) begin
          w_next = ARB_GNT_I;
        end else if (w_d_req) begin
          w_next = ARB_GNT_D;
        end
      end

      ARB_GNT_I: begin
        gnt     = 2'b01;
        s_cyc   = i_cyc;
        s_stb   = i_stb;
        s_we    = i_we;
        s_adr   = i_adr;
        s_sel   = i_sel;
        s_dat_m = i_dat_m;
        i_ack   = s_ack;
        i_rty   = s_rty;
        // A slave response wins over both the watchdog and a dropped cyc.
        if (w_resp || w_timeout) begin
          if (!w_resp) begin
            s_cyc = 1'b0;
            s_stb = 1'b0;
            i_rty = 1'b1;
          end
          w_last_nxt = 1'b0;
          w_wd_clr   = 1'b1;
          w_next     = w_d_req ? ARB_GNT_D : ARB_IDLE;
        end else if (!i_cyc) begin
          w_last_nxt = 1'b0;
          w_wd_clr   = 1'b1;
          w_next     = ARB_IDLE;
        end else begin
          w_wd_en = 1'b1;
        end
      end

      ARB_GNT_D: begin
        gnt   = 2'b10;
        s_cyc = d_cyc;
        s_stb = d_stb;
        d_ack = s_ack;
        d_rty = s_rty;
        if (w_resp || w_timeout) begin
          if (!w_resp) begin
            s_cyc = 1'b0;
            s_stb = 1'b0;
            d_rty = 1'b1;
          end
          w_last_nxt = 1'b1;
          w_wd_clr   = 1'b1;
          w_next     = w_i_req ? ARB_GNT_I : ARB_IDLE;
        end else if (!d_cyc) begin
          w_last_nxt = 1'b1;
          w_wd_clr   = 1'b1;
          w_next     = ARB_IDLE;
        end else begin
          w_wd_en = 1'b1;
        end
      end

      default: begin
        w_next = ARB_IDLE;
      end
    endcase

    // Reset drops the slave cycle and all responses in the same cycle.
    if (rst) begin
      s_cyc = 1'b0;
      s_stb = 1'b0;
      i_ack = 1'b0;
      i_rty = 1'b0;
      d_ack = 1'b0;
      d_rty = 1'b0;
    end
  end

endmodule
`default_nettype wire
